fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage: owns the fetch PC, drives a synchronous (1-cycle) instruction ROM,

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_buffer.sv | 77 +++++++
 rtl/fetch_buffer_chk.sv | 16 +
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Buffer entries pair each instruction word with the byte PC it was fetched from.
package fetch_pkg;

    localparam int PC_W        = 32;
    localparam int INSTR_ALIGN = 2;
    localparam int INSTR_W     = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    // Low address bits of a byte PC are not part of the word address.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:INSTR_ALIGN], {INSTR_ALIGN{1'b0}}};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
// Flush dominates any push or pop in the same cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against flush and an empty buffer.
    always_comb begin
        do_push_s = push & ~flush;
        do_pop_s  = pop & ~flush & (count_r != {CNT_W{1'b0}});
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

    fetch_buffer_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .flush (flush),
        .count (count_r)
    );

endmodule

// File: rtl/fetch_buffer_chk.sv
// Protocol checker for fetch_buffer: a push must always find a free slot.
module fetch_buffer_chk #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic             flush,
    input logic [CNT_W-1:0] count
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push && !flush) |-> (count < CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle ROM, buffers returned
// words and presents {instr, pc} to decode; redirects flush and restart the stream.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W    = 15,
    parameter int              DATA_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [PC_W-1:0]   fetch_pc_r;
    logic [PC_W-1:0]   inflight_pc_r;
    logic              inflight_r;
    logic [PC_W-1:0]   last_pc_r;
    logic [DATA_W-1:0] last_instr_r;
    logic [PC_W-1:0]   req_pc_s;
    logic              pop_s;
    logic              push_s;
    logic              credit_s;
    logic [CNT_W-1:0]  count_s;
    fetch_entry_t      push_entry_s;
    fetch_entry_t      head_s;

    // Output from the buffer head; when empty, keep showing the last accepted word.
    always_comb begin
        out_valid = (count_s != {CNT_W{1'b0}});
        if (out_valid) begin
            out_instr = DATA_W'(head_s.instr);
            out_pc    = head_s.pc;
        end else begin
            out_instr = last_instr_r;
            out_pc    = last_pc_r;
        end
    end

    // Issue decision: redirect overrides credit; the in-flight word is dropped on redirect.
    always_comb begin
        pop_s              = out_valid & out_ready;
        push_s             = inflight_r & ~redirect_valid;
        push_entry_s.instr = INSTR_W'(rom_data);
        push_entry_s.pc    = inflight_pc_r;
        // Words already owed to the buffer (held + in flight), net of this cycle's pop.
        credit_s = ({1'b0, count_s} + (CNT_W+1)'(inflight_r))
                 < ((CNT_W+1)'(BUF_DEPTH) + (CNT_W+1)'(pop_s));
        if (rst) begin
            rom_en   = 1'b0;
            req_pc_s = fetch_pc_r;
        end else if (redirect_valid) begin
            rom_en   = 1'b1;
            req_pc_s = align_pc(redirect_pc);
        end else if (credit_s) begin
            rom_en   = 1'b1;
            req_pc_s = fetch_pc_r;
        end else begin
            rom_en   = 1'b0;
            req_pc_s = fetch_pc_r;
        end
        rom_addr = req_pc_s[ADDR_W+1:INSTR_ALIGN];
    end

    // Fetch PC, in-flight request tracking and the hold copy of the last output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            last_pc_r     <= 32'h0000_0000;
            last_instr_r  <= {DATA_W{1'b0}};
        end else begin
            inflight_r <= rom_en;
            if (rom_en) begin
                fetch_pc_r    <= req_pc_s + 32'd4;
                inflight_pc_r <= req_pc_s;
            end
            if (pop_s) begin
                last_pc_r    <= out_pc;
                last_instr_r <= out_instr;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .head      (head_s),
        .count     (count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: request-timeline reference model plus directed scenarios
// and randomized ready/redirect traffic.
module tb_fetch_unit;

    localparam int          ADDR_W    = 15;
    localparam int          DATA_W    = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [31:0]       out_pc;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    // ROM holds its own word index; data is garbage unless it was read the cycle before.
    always @(posedge clk) begin
        rom_data <= rom_en ? {17'd0, rom_addr} : 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return {17'd0, pc[16:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: every request becomes visible two cycles after issue, in order;
    // a redirect discards everything not yet accepted; issue is allowed while fewer than
    // BUF_DEPTH words would remain owed after this cycle's acceptance.
    typedef struct {
        logic [31:0] pc;
        int          avail;
    } req_t;

    req_t        q[$];
    logic [31:0] m_next_pc = RESET_PC;
    int          cyc = 0;

    always @(negedge clk) begin : cmp
        bit          ev;
        bit          pop;
        bit          een;
        logic [31:0] rpc;
        cyc++;
        if (rst) begin
            q.delete();
            m_next_pc = RESET_PC;
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_rom_en", 32'(rom_en), 32'd0);
            chk("rst_pc", out_pc, 32'd0);
            chk("rst_instr", out_instr, 32'd0);
        end else begin
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            chk("valid", 32'(out_valid), 32'(ev));
            if (ev) begin
                chk("pc", out_pc, q[0].pc);
                chk("instr", out_instr, rom_word(q[0].pc));
            end
            pop = ev && out_ready;
            een = redirect_valid || ((q.size() - int'(pop)) < BUF_DEPTH);
            rpc = redirect_valid ? (redirect_pc & ~32'h0000_0003) : m_next_pc;
            chk("rom_en", 32'(rom_en), 32'(een));
            if (een) chk("rom_addr", 32'(rom_addr), 32'(rpc[16:2]));
            if (pop) void'(q.pop_front());
            if (redirect_valid) q.delete();
            if (een) begin
                q.push_back('{rpc, cyc + 2});
                m_next_pc = rpc + 32'd4;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        bit found;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        // Reset release: sequential fetch, first output two cycles later.
        #1 rst = 1'b0;
        out_ready = 1'b1;
        #1 chk("a_en0", 32'(rom_en), 32'd1);
        chk("a_addr0", 32'(rom_addr), 32'h0);
        step(); #1 chk("a_addr1", 32'(rom_addr), 32'h1);
        step(); #1 chk("a_valid2", 32'(out_valid), 32'd1);
        chk("a_pc2", out_pc, 32'h0);
        step(); #1 chk("a_pc3", out_pc, 32'h4);
        chk("a_instr3", out_instr, 32'h1);

        // Stall at 0x10: fetch stops once the buffer is full, data holds, resumes cleanly.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (out_valid && out_pc == 32'h10) found = 1'b1;
        end
        if (!found) chk("b_wait_pc10", out_pc, 32'h10);
        out_ready = 1'b0;
        repeat (4) step();
        #1 chk("b_stall_en", 32'(rom_en), 32'd0);
        chk("b_hold_pc", out_pc, 32'h10);
        step(); out_ready = 1'b1;
        step(); #1 chk("b_resume_pc", out_pc, 32'h14);

        // Redirect while the buffer is full.
        out_ready = 1'b0;
        repeat (4) step();
        step(); out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1 chk("c_en", 32'(rom_en), 32'd1);
        chk("c_addr", 32'(rom_addr), 32'h80);
        step(); redirect_valid = 1'b0;
        #1 chk("c_gap", 32'(out_valid), 32'd0);
        step(); #1 chk("c_valid", 32'(out_valid), 32'd1);
        chk("c_pc", out_pc, 32'h200);

        // Back-to-back redirects: only the second target survives.
        step(); redirect_valid = 1'b1; redirect_pc = 32'h40;
        step(); redirect_pc = 32'h80;
        step(); redirect_valid = 1'b0;
        step(); #1 chk("d_pc", out_pc, 32'h80);

        // Unaligned target and PC/address wrap.
        step(); redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1 chk("e_addr", 32'(rom_addr), 32'h40);
        step(); redirect_valid = 1'b0;
        step(); #1 chk("e_pc", out_pc, 32'h100);
        step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1 chk("e_wrap_addr", 32'(rom_addr), 32'h7FFF);
        step(); redirect_valid = 1'b0;
        #1 chk("e_wrap_next", 32'(rom_addr), 32'h0);
        step(); #1 chk("e_wrap_pc0", out_pc, 32'hFFFF_FFFC);
        step(); #1 chk("e_wrap_pc1", out_pc, 32'h0);

        // Random back-pressure and redirects.
        for (int i = 0; i < 400; i++) begin
            step();
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;
        end
        step(); redirect_valid = 1'b0; out_ready = 1'b1;

        // Asynchronous reset mid-stream.
        repeat (5) step();
        chk("g_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1 chk("g_valid", 32'(out_valid), 32'd0);
        chk("g_en", 32'(rom_en), 32'd0);
        step(); step(); rst = 1'b0;
        #1 chk("g_addr", 32'(rom_addr), 32'h0);
        step(); step(); #1 chk("g_pc0", out_pc, RESET_PC);
        step(); #1 chk("g_pc1", out_pc, RESET_PC + 32'd4);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
